// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (IF) and load/store (LS).
// Define MEM_ARB_PERF_EN to add grant/conflict performance counters.
module mem_port_arbiter #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned MEM_DEPTH    = 1000,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              If_req,
    input  logic [ADDR_W-1:0] If_addr,
    output logic [DATA_W-1:0] If_rdata,
    output logic              If_ready,
    input  logic              Ls_read,
    input  logic              Ls_write,
    input  logic [ADDR_W-1:0] Ls_addr,
    input  logic [DATA_W-1:0] Ls_wdata,
    output logic [DATA_W-1:0] Ls_rdata,
    output logic              Ls_ready,
    output logic              Addr_err,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0]       If_grant_cnt,
    output logic [31:0]       Ls_grant_cnt,
    output logic [31:0]       Conflict_cnt,
`endif
    output logic [ADDR_W-1:0] Mem_address,
    output logic [DATA_W-1:0] Mem_write_data,
    output logic              Mem_read,
    output logic              Mem_write,
    input  logic [DATA_W-1:0] Mem_read_data
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp, StDone} state_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    state_e            r_state;
    logic              r_owner_ls;
    logic              r_oor;
    logic [3:0]        r_starve;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_ls_rdata;
    logic              r_if_ready;
    logic              r_ls_ready;
    logic              r_addr_err;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_write_data;
    logic              r_mem_read;
    logic              r_mem_write;

    logic              w_idle;
    logic              w_ls_req;
    logic              w_grant_if;
    logic              w_grant_ls;
    logic              w_ls_is_write;
    logic [ADDR_W-1:0] w_addr;
    logic              w_oor;

    assign w_idle        = (r_state == StIdle);
    assign w_ls_req      = Ls_read | Ls_write;
    // IF wins only when LS is silent or IF has been starved long enough
    assign w_grant_if    = w_idle & If_req & (~w_ls_req | (r_starve == StarveMax));
    assign w_grant_ls    = w_idle & w_ls_req & ~w_grant_if;
    // Read takes priority when both LS strobes are high
    assign w_ls_is_write = Ls_write & ~Ls_read;
    assign w_addr        = w_grant_if ? If_addr : Ls_addr;
    assign w_oor         = (w_addr >= ADDR_W'(MEM_DEPTH));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state          <= StIdle;
            r_owner_ls       <= 1'b0;
            r_oor            <= 1'b0;
            r_starve         <= 4'd0;
            r_if_rdata       <= '0;
            r_ls_rdata       <= '0;
            r_if_ready       <= 1'b0;
            r_ls_ready       <= 1'b0;
            r_addr_err       <= 1'b0;
            r_mem_address    <= '0;
            r_mem_write_data <= '0;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
        end else begin
            r_if_ready <= 1'b0;
            r_ls_ready <= 1'b0;
            r_addr_err <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (!If_req || w_grant_if) begin
                        r_starve <= 4'd0;
                    end else if (w_grant_ls && r_starve != StarveMax) begin
                        r_starve <= r_starve + 4'd1;
                    end
                    if (w_grant_if || w_grant_ls) begin
                        r_owner_ls    <= w_grant_ls;
                        r_oor         <= w_oor;
                        r_mem_address <= w_addr;
                        if (w_grant_ls) begin
                            r_mem_write_data <= Ls_wdata;
                        end
                        r_mem_read  <= ~w_oor & ~(w_grant_ls & w_ls_is_write);
                        r_mem_write <= ~w_oor & w_grant_ls & w_ls_is_write;
                        r_state     <= StIssue;
                    end
                end
                StIssue: begin
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    if (r_oor) begin
                        if (r_owner_ls) r_ls_rdata <= '0;
                        else            r_if_rdata <= '0;
                        r_addr_err <= 1'b1;
                        r_if_ready <= ~r_owner_ls;
                        r_ls_ready <= r_owner_ls;
                        r_state    <= StDone;
                    end else if (r_mem_write) begin
                        r_ls_ready <= 1'b1;
                        r_state    <= StDone;
                    end else begin
                        r_state <= StResp;
                    end
                end
                StResp: begin
                    if (r_owner_ls) r_ls_rdata <= Mem_read_data;
                    else            r_if_rdata <= Mem_read_data;
                    r_if_ready <= ~r_owner_ls;
                    r_ls_ready <= r_owner_ls;
                    r_state    <= StDone;
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] r_if_grant_cnt;
    logic [31:0] r_ls_grant_cnt;
    logic [31:0] r_conflict_cnt;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_if_grant_cnt <= '0;
            r_ls_grant_cnt <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_grant_if) r_if_grant_cnt <= r_if_grant_cnt + 32'd1;
            if (w_grant_ls) r_ls_grant_cnt <= r_ls_grant_cnt + 32'd1;
            if (w_idle && If_req && w_ls_req) r_conflict_cnt <= r_conflict_cnt + 32'd1;
        end
    end

    assign If_grant_cnt = r_if_grant_cnt;
    assign Ls_grant_cnt = r_ls_grant_cnt;
    assign Conflict_cnt = r_conflict_cnt;
`endif

    assign If_rdata       = r_if_rdata;
    assign Ls_rdata       = r_ls_rdata;
    assign If_ready       = r_if_ready;
    assign Ls_ready       = r_ls_ready;
    assign Addr_err       = r_addr_err;
    assign Mem_address    = r_mem_address;
    assign Mem_write_data = r_mem_write_data;
    assign Mem_read       = r_mem_read;
    assign Mem_write      = r_mem_write;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural one-cycle-read memory.
module tb_mem_port_arbiter;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        If_req = 1'b0;
    logic [31:0] If_addr = '0;
    logic [31:0] If_rdata;
    logic        If_ready;
    logic        Ls_read = 1'b0;
    logic        Ls_write = 1'b0;
    logic [31:0] Ls_addr = '0;
    logic [31:0] Ls_wdata = '0;
    logic [31:0] Ls_rdata;
    logic        Ls_ready;
    logic        Addr_err;
    logic [31:0] Mem_address;
    logic [31:0] Mem_write_data;
    logic        Mem_read;
    logic        Mem_write;
    logic [31:0] Mem_read_data = '0;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] If_grant_cnt;
    logic [31:0] Ls_grant_cnt;
    logic [31:0] Conflict_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int n_rd = 0;
    int n_wr = 0;
    logic preload = 1'b1;
    logic [31:0] mem [0:1023] = '{default: '0};

    always #5 Clk = ~Clk;

    mem_port_arbiter #(
        .DATA_W(32), .ADDR_W(32), .MEM_DEPTH(1000), .STARVE_LIMIT(2)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .If_req(If_req), .If_addr(If_addr), .If_rdata(If_rdata), .If_ready(If_ready),
        .Ls_read(Ls_read), .Ls_write(Ls_write), .Ls_addr(Ls_addr), .Ls_wdata(Ls_wdata),
        .Ls_rdata(Ls_rdata), .Ls_ready(Ls_ready), .Addr_err(Addr_err),
`ifdef MEM_ARB_PERF_EN
        .If_grant_cnt(If_grant_cnt), .Ls_grant_cnt(Ls_grant_cnt),
        .Conflict_cnt(Conflict_cnt),
`endif
        .Mem_address(Mem_address), .Mem_write_data(Mem_write_data),
        .Mem_read(Mem_read), .Mem_write(Mem_write), .Mem_read_data(Mem_read_data)
    );

    // Single-port memory: registered read, read wins over write
    always @(posedge Clk) begin
        if (preload) begin
            mem[5] <= 32'hDEAD_BEEF;
            mem[7] <= 32'h0000_0777;
        end else if (Mem_read) begin
            Mem_read_data <= mem[Mem_address[9:0]];
        end else if (Mem_write) begin
            mem[Mem_address[9:0]] <= Mem_write_data;
        end
        if (Mem_read)  n_rd <= n_rd + 1;
        if (Mem_write) n_wr <= n_wr + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input logic ls, input int exp_lat, input string tag);
        int lat;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge Clk);
            if ((ls ? Ls_ready : If_ready) === 1'b1) begin
                lat = c;
                break;
            end
        end
        check(tag, 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        int rd0;
        int wr0;
        logic got_if;
        logic [5:0] exp_order;

        // Reset held for two cycles
        @(negedge Clk);
        preload = 1'b0;
        check("reset_outs", {If_ready, Ls_ready, Addr_err, Mem_read, Mem_write},  5'b0);
        check("reset_data", {If_rdata, Ls_rdata}, 64'h0);
        check("reset_mem",  {Mem_address, Mem_write_data}, 64'h0);
        @(negedge Clk);
        Rst = 1'b0;
        If_req = 1'b1;
        If_addr = 32'd5;
        wait_ready(1'b0, 3, "if_read_lat");
        check("if_read_data", {32'h0, If_rdata}, 64'hDEAD_BEEF);
        check("if_read_err", {63'h0, Addr_err}, 64'h0);
        If_req = 1'b0;
        @(negedge Clk);

        // LS write then read back
        wr0 = n_wr;
        Ls_write = 1'b1;
        Ls_addr = 32'd10;
        Ls_wdata = 32'h1234_5678;
        wait_ready(1'b1, 2, "ls_write_lat");
        check("ls_write_strobes", 64'(n_wr - wr0), 64'd1);
        check("ls_write_mem", {32'h0, mem[10]}, 64'h1234_5678);
        Ls_write = 1'b0;
        @(negedge Clk);
        Ls_read = 1'b1;
        wait_ready(1'b1, 3, "ls_read_lat");
        check("ls_read_data", {32'h0, Ls_rdata}, 64'h1234_5678);
        check("if_rdata_held", {32'h0, If_rdata}, 64'hDEAD_BEEF);
        Ls_read = 1'b0;
        @(negedge Clk);

        // Out-of-range read
        rd0 = n_rd;
        Ls_read = 1'b1;
        Ls_addr = 32'd1000;
        wait_ready(1'b1, 2, "oor_lat");
        check("oor_err", {63'h0, Addr_err}, 64'h1);
        check("oor_rdata", {32'h0, Ls_rdata}, 64'h0);
        check("oor_no_strobe", 64'(n_rd - rd0), 64'd0);
        Ls_read = 1'b0;
        @(negedge Clk);
        check("oor_err_pulse", {63'h0, Addr_err}, 64'h0);

        // Both ports requesting continuously: order LS, LS, IF, LS, LS, IF
        exp_order = 6'b100100;
        If_req = 1'b1;
        If_addr = 32'd5;
        Ls_read = 1'b1;
        Ls_addr = 32'd10;
        for (int g = 0; g < 6; g++) begin
            got_if = 1'bx;
            for (int c = 0; c < 20; c++) begin
                @(negedge Clk);
                if (If_ready === 1'b1 || Ls_ready === 1'b1) begin
                    got_if = If_ready;
                    break;
                end
            end
            check($sformatf("grant_order_%0d", g), {63'h0, got_if}, {63'h0, exp_order[g]});
        end
        check("starve_if_data", {32'h0, If_rdata}, 64'hDEAD_BEEF);
        check("starve_ls_data", {32'h0, Ls_rdata}, 64'h1234_5678);
        If_req = 1'b0;
        Ls_read = 1'b0;
        @(negedge Clk);

        // Reset while the read is in RESP
        If_req = 1'b1;
        If_addr = 32'd7;
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        check("midrst_no_ready", {62'h0, If_ready, Ls_ready}, 64'h0);
        check("midrst_rdata", {32'h0, If_rdata}, 64'h0);
        Rst = 1'b0;
        wait_ready(1'b0, 3, "midrst_fresh_lat");
        check("midrst_fresh_data", {32'h0, If_rdata}, 64'h777);
        If_req = 1'b0;
        @(negedge Clk);

        // Read and write together behave as a read only
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        rd0 = n_rd;
        wr0 = n_wr;
        Ls_read = 1'b1;
        Ls_write = 1'b1;
        Ls_addr = 32'd7;
        Ls_wdata = 32'hBAD0_BAD0;
        wait_ready(1'b1, 3, "rw_lat");
        check("rw_reads", 64'(n_rd - rd0), 64'd1);
        check("rw_writes", 64'(n_wr - wr0), 64'd0);
        check("rw_mem7", {32'h0, mem[7]}, 64'h777);
        check("rw_rdata", {32'h0, Ls_rdata}, 64'h777);
`ifdef MEM_ARB_PERF_EN
        check("rw_ls_grants", {32'h0, Ls_grant_cnt}, 64'd1);
        check("rw_if_grants", {32'h0, If_grant_cnt}, 64'd0);
`endif
        Ls_read = 1'b0;
        Ls_write = 1'b0;
        @(negedge Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port data/instruction memory between the instruction-fetch port (IF) and the load/store port (LS).
- Arbitrates requests, sequences the memory's one-cycle registered read, and returns data with a ready pulse.
- Sits between the pipeline's fetch/memory stages and the memory block, and drives its Address, Write_data, Mem_read and Mem_write.

Parameters:
- DATA_W, 32, data width of all data buses.
- ADDR_W, 32, address width of all address buses.
- MEM_DEPTH, 1000, number of valid word addresses (0..MEM_DEPTH-1).
- STARVE_LIMIT, 4, consecutive lost arbitrations after which IF is forced to win (range 1..15).

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  reset; synchronous, active-high.
- If_req  in  1  IF read request; held until If_ready.
- If_addr  in  ADDR_W  IF word address.
- If_rdata  out  DATA_W  IF read data, valid when If_ready=1, held until next IF completion.
- If_ready  out  1  one-cycle completion pulse.
- Ls_read  in  1  LS read request; held until Ls_ready.
- Ls_write  in  1  LS write request; held until Ls_ready.
- Ls_addr  in  ADDR_W  LS word address.
- Ls_wdata  in  DATA_W  LS write data.
- Ls_rdata  out  DATA_W  LS read data, same rules as If_rdata.
- Ls_ready  out  1  one-cycle completion pulse.
- Addr_err  out  1  pulses together with ready when the completed access was out of range.
- Mem_address  out  ADDR_W  memory address.
- Mem_write_data  out  DATA_W  memory write data.
- Mem_read  out  1  memory read strobe.
- Mem_write  out  1  memory write strobe.
- Mem_read_data  in  DATA_W  memory read data, valid in the cycle after the Mem_read edge.

Behaviour:
- Reset (synchronous): FSM goes to IDLE. All outputs are 0, including rdata registers, Mem_* outputs, the starvation counter and the error flag.
- Reset mid-operation abandons the in-flight access. No ready pulse is issued. A write already sampled by memory stands.
- All memory-side outputs are registered.
- FSM states:
  - IDLE: evaluate requests. On a grant, latch owner, address, data and op; go to ISSUE. With no request, stay in IDLE.
  - ISSUE: drive Mem_address and Mem_read or Mem_write for exactly one cycle.
    - Read → RESP.
    - Write → DONE.
    - Out-of-range access (addr ≥ MEM_DEPTH): no strobe asserted, rdata register forced to 0, go to DONE, error flag set.
  - RESP: capture Mem_read_data into the owner's rdata register at the end of the cycle; → DONE.
  - DONE: owner's ready=1 and Addr_err=flag for one cycle. No grant is made in this cycle. → IDLE.
- Latency, counted from the request-visible IDLE cycle as cycle 0:
  - Read: ready in cycle 3.
  - Write: ready in cycle 2.
  - Out-of-range: ready in cycle 2.
- Both strobes are 0 in IDLE, RESP and DONE.
- Ls_read and Ls_write both high: treated as a read and the write is ignored (matches the memory's read-over-write priority).
- Arbitration (IDLE only):
  - LS wins by default.
  - Starvation counter increments each IDLE grant that IF loses while If_req=1. It clears when IF is granted or when If_req=0 in IDLE, and saturates at STARVE_LIMIT.
  - Counter = STARVE_LIMIT forces IF to win at the next grant.
- Requester protocol: inputs must stay stable from request until ready. The arbiter latches them at grant and ignores later changes.
- Request dropped before ready: the access still completes and ready still pulses.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined:
  - Adds outputs If_grant_cnt, Ls_grant_cnt, Conflict_cnt (32 bits each, cleared by Rst).
  - The grant counters increment on each grant to their port.
  - Conflict_cnt increments on each IDLE cycle in which both ports request.
  - All three wrap at 2^32.
- Undefined: these ports and registers are absent; behaviour is otherwise identical.

Test Plan:
- Reset: memory preloaded with mem[5]=0xDEADBEEF. Hold Rst 2 cycles, then If_req=1, If_addr=5 → all outputs 0 during reset; If_ready in cycle 3 after release; If_rdata=0xDEADBEEF.
- LS write then read: Ls_write addr 10 data 0x12345678 → Ls_ready in cycle 2. Then Ls_read addr 10 → Ls_ready 3 cycles later with Ls_rdata=0x12345678.
- Simultaneous requests with STARVE_LIMIT=2: If_req and Ls_read continuously asserted → grant order LS, LS, IF, LS, LS, IF; IF never waits more than 2 grants.
- Out-of-range: Ls_read addr 1000 → Mem_read never asserted; Ls_ready and Addr_err together in cycle 2; Ls_rdata=0.
- Reset mid-read: Rst asserted in the RESP state → no If_ready pulse; FSM in IDLE next cycle; a fresh request completes normally.
- Read+write collision: Ls_read=Ls_write=1, addr 7 → Mem_read only, mem[7] unchanged (with MEM_ARB_PERF_EN, Ls_grant_cnt=1).
